// File: rtl/seqdet_pkg.sv
// Shared constants for the sequence-detector front end.
// The SEQDET_PARITY_EN macro selects a W+1-bit frame that ends in an even-parity bit.
package seqdet_pkg;

   localparam int SEQDET_W = 8;

`ifdef SEQDET_PARITY_EN
   localparam int SEQDET_FRAME_LEN = SEQDET_W + 1;
`else
   localparam int SEQDET_FRAME_LEN = SEQDET_W;
`endif

   localparam int SEQDET_CNT_W = $clog2(SEQDET_W + 1);

endpackage : seqdet_pkg

// File: rtl/sba_out_reg.sv
// Output holding register for serial_byte_assembler: load, transfer and drop rules.
// The SEQDET_PARITY_EN macro adds a parity_err flag that is held alongside the word.
module sba_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_word,
`ifdef SEQDET_PARITY_EN
   input  logic         load_perr,
`endif
   input  logic         out_ready,
   input  logic         clear,
   output logic [W-1:0] byte_out,
   output logic         byte_valid,
   output logic         overflow
`ifdef SEQDET_PARITY_EN
   ,
   output logic         parity_err
`endif
);

   logic [W-1:0] word_q, word_d;
   logic         valid_q, valid_d;
   logic         ovf_q, ovf_d;
`ifdef SEQDET_PARITY_EN
   logic         perr_q, perr_d;
`endif

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
`ifdef SEQDET_PARITY_EN
      perr_d  = perr_q;
`endif
      // A slot is free when empty or being consumed this cycle; a reload beats the transfer.
      if (load && (!valid_q || out_ready)) begin
         word_d  = load_word;
         valid_d = 1'b1;
`ifdef SEQDET_PARITY_EN
         perr_d  = load_perr;
`endif
      end else if (load) begin
         ovf_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (clear) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SEQDET_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
`ifdef SEQDET_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign byte_out   = word_q;
   assign byte_valid = valid_q;
   assign overflow   = ovf_q;
`ifdef SEQDET_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule : sba_out_reg

// File: rtl/serial_byte_assembler.sv
// Serial-to-word assembler (MSB first) with valid/ready output and sticky overflow.
// Defining SEQDET_PARITY_EN adds a trailing even-parity bit per frame and the parity_err output.
module serial_byte_assembler
   import seqdet_pkg::*;
#(
   parameter int W = SEQDET_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bit_in,
   input  logic                    bit_valid,
   input  logic                    clear,
   input  logic                    out_ready,
   output logic [W-1:0]            byte_out,
   output logic                    byte_valid,
   output logic                    overflow,
   output logic [SEQDET_CNT_W-1:0] bit_cnt
`ifdef SEQDET_PARITY_EN
   ,
   output logic                    parity_err
`endif
);

   // Only FRAME_LEN-1 bits are stored; the final bit is taken live from bit_in on completion.
   localparam int SW = SEQDET_FRAME_LEN - 1;
   localparam logic [SEQDET_CNT_W-1:0] LAST_IDX = SEQDET_CNT_W'(SEQDET_FRAME_LEN - 1);

   logic [SW-1:0]           shreg_q, shreg_d;
   logic [SEQDET_CNT_W-1:0] cnt_q, cnt_d;
   logic                    frame_done;
   logic [W-1:0]            done_word;

   always_comb begin
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      frame_done = 1'b0;
      if (clear) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (bit_valid) begin
         shreg_d = {shreg_q[SW-2:0], bit_in};
         if (cnt_q == LAST_IDX) begin
            cnt_d      = '0;
            frame_done = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SEQDET_PARITY_EN
   logic done_perr;
   assign done_word = shreg_q;
   assign done_perr = (^shreg_q) ^ bit_in;
`else
   assign done_word = {shreg_q, bit_in};
`endif

   sba_out_reg #(
      .W (W)
   ) u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (frame_done),
      .load_word  (done_word),
`ifdef SEQDET_PARITY_EN
      .load_perr  (done_perr),
`endif
      .out_ready  (out_ready),
      .clear      (clear),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .overflow   (overflow)
`ifdef SEQDET_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   assign bit_cnt = cnt_q;

endmodule : serial_byte_assembler

// File: tb/tb_serial_byte_assembler.sv
// Directed self-checking bench for serial_byte_assembler (parity checks only with SEQDET_PARITY_EN).
module tb_serial_byte_assembler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       overflow;
   logic [3:0] bit_cnt;
`ifdef SEQDET_PARITY_EN
   logic       parity_err;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_byte_assembler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .clear      (clear),
      .out_ready  (out_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .overflow   (overflow),
      .bit_cnt    (bit_cnt)
`ifdef SEQDET_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
   endtask

   // Sends a word MSB first; in the parity build a trailing parity bit follows.
   task automatic send_word(input logic [7:0] w, input logic pbit);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SEQDET_PARITY_EN
      send_bit(pbit);
`else
      if (pbit) ; // parity bit unused without the parity frame
`endif
   endtask

   task automatic send_good(input logic [7:0] w);
      send_word(w, ^w);
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'hB2;

      // Reset state
      #2;
      check("rst_valid", {31'd0, byte_valid}, 32'd0);
      check("rst_byte", {24'd0, byte_out}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_cnt", {28'd0, bit_cnt}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: one bit per cycle, consumer ready
      out_ready = 1'b1;
      for (int i = 7; i >= 1; i--) send_bit(pat[i]);
      check("t1_cnt7", {28'd0, bit_cnt}, 32'd7);
      check("t1_valid_pre", {31'd0, byte_valid}, 32'd0);
`ifdef SEQDET_PARITY_EN
      send_bit(pat[0]);
      send_bit(1'b0);
      check("t1_perr", {31'd0, parity_err}, 32'd0);
`else
      send_bit(pat[0]);
`endif
      check("t1_byte", {24'd0, byte_out}, 32'hB2);
      check("t1_valid", {31'd0, byte_valid}, 32'd1);
      check("t1_cnt0", {28'd0, bit_cnt}, 32'd0);
      tick();
      check("t1_valid_off", {31'd0, byte_valid}, 32'd0);

      // 2: bit_valid every third cycle
      for (int i = 7; i >= 1; i--) begin
         send_bit(pat[i]);
         tick();
         tick();
      end
      check("t2_valid_pre", {31'd0, byte_valid}, 32'd0);
      check("t2_cnt7", {28'd0, bit_cnt}, 32'd7);
`ifdef SEQDET_PARITY_EN
      send_bit(pat[0]);
      tick();
      tick();
      send_bit(1'b0);
`else
      send_bit(pat[0]);
`endif
      check("t2_byte", {24'd0, byte_out}, 32'hB2);
      check("t2_valid", {31'd0, byte_valid}, 32'd1);
      tick();

      // 3: backpressure drops the second word
      out_ready = 1'b0;
      send_good(8'hB2);
      check("t3_byte1", {24'd0, byte_out}, 32'hB2);
      check("t3_ovf0", {31'd0, overflow}, 32'd0);
      send_good(8'h5A);
      check("t3_byte_hold", {24'd0, byte_out}, 32'hB2);
      check("t3_ovf1", {31'd0, overflow}, 32'd1);
      check("t3_valid", {31'd0, byte_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      check("t3_valid_off", {31'd0, byte_valid}, 32'd0);
      check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

      // 4: reload on the same edge as a transfer
      send_good(8'h5A);
      check("t4_byte1", {24'd0, byte_out}, 32'h5A);
      out_ready = 1'b0;
      pat = 8'hC3;
      for (int i = 7; i >= 1; i--) send_bit(pat[i]);
      check("t4_hold", {24'd0, byte_out}, 32'h5A);
      out_ready = 1'b1;
`ifdef SEQDET_PARITY_EN
      send_bit(pat[0]);
      send_bit(^pat);
`else
      send_bit(pat[0]);
`endif
      check("t4_byte2", {24'd0, byte_out}, 32'hC3);
      check("t4_valid", {31'd0, byte_valid}, 32'd1);
      check("t4_ovf", {31'd0, overflow}, 32'd0);
      tick();
      check("t4_valid_off", {31'd0, byte_valid}, 32'd0);

      // 5: clear discards a partial frame
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check("t5_cnt5", {28'd0, bit_cnt}, 32'd5);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t5_cnt_clr", {28'd0, bit_cnt}, 32'd0);
      send_good(8'h0F);
      check("t5_byte", {24'd0, byte_out}, 32'h0F);
      tick();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      clear = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
      clear = 1'b0;
      bit_valid = 1'b0;
      check("t5_clr_win", {28'd0, bit_cnt}, 32'd0);
      send_good(8'hA5);
      check("t5_byte2", {24'd0, byte_out}, 32'hA5);
      tick();

`ifdef SEQDET_PARITY_EN
      // 6a: parity error flag
      send_word(8'hB2, 1'b0);
      check("t6_perr0", {31'd0, parity_err}, 32'd0);
      send_word(8'hB2, 1'b1);
      check("t6_perr1", {31'd0, parity_err}, 32'd1);
      check("t6_pbyte", {24'd0, byte_out}, 32'hB2);
      tick();
`endif

      // 6b: asynchronous reset mid-frame
      out_ready = 1'b0;
      send_good(8'h5A);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("t6_cnt4", {28'd0, bit_cnt}, 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, byte_valid}, 32'd0);
      check("t6_rst_byte", {24'd0, byte_out}, 32'd0);
      check("t6_rst_cnt", {28'd0, bit_cnt}, 32'd0);
      check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      send_good(8'h3C);
      check("t6_byte", {24'd0, byte_out}, 32'h3C);
      check("t6_valid", {31'd0, byte_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_byte_assembler
